exc_commit_ctrl: RTL and testbench

Exception/interrupt commit controller sitting between the writeback stage, the CSR file and the fetch stage. Every cycle it arbitrates exception sources and pending interrupts against the instruction in writeback. It drives the CSR file's exception-entry and ertn strobes, flushes the pipeline, and sequences a valid/ready redirect handshake to fetch toward EENTRY or ERA.

---
 rtl/exc_commit_ctrl_if.sv | 42 ++++
 rtl/exc_commit_ctrl.sv | 87 ++++++++
 tb/tb_exc_commit_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_ctrl_if.sv
// Writeback/CSR/fetch signal bundle for the exception commit controller.
// The slave modport is the controller; the master side is the surrounding pipeline.
interface exc_commit_ctrl_if #(
    parameter int EX_CNT_W = 32
);
    logic                wb_valid;
    logic [31:0]         wb_pc;
    logic [31:0]         wb_vaddr;
    logic [4:0]          wb_exc;
    logic                wb_ertn;
    logic                crmd_ie;
    logic [12:0]         ecfg_lie;
    logic [12:0]         estat_is;
    logic [31:0]         eentry;
    logic [31:0]         era;
    logic                wb_ex;
    logic [5:0]          wb_ecode;
    logic [8:0]          wb_esubcode;
    logic [31:0]         ex_pc;
    logic [31:0]         ex_vaddr;
    logic                ertn_flush;
    logic                wb_commit;
    logic                flush;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                redirect_ready;
    logic [EX_CNT_W-1:0] ex_cnt;

    modport slave (
        input  wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn, crmd_ie, ecfg_lie,
               estat_is, eentry, era, redirect_ready,
        output wb_ex, wb_ecode, wb_esubcode, ex_pc, ex_vaddr, ertn_flush,
               wb_commit, flush, redirect_valid, redirect_pc, ex_cnt
    );

    modport master (
        output wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn, crmd_ie, ecfg_lie,
               estat_is, eentry, era, redirect_ready,
        input  wb_ex, wb_ecode, wb_esubcode, ex_pc, ex_vaddr, ertn_flush,
               wb_commit, flush, redirect_valid, redirect_pc, ex_cnt
    );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller: arbitrates the writeback instruction against
// exceptions and pending interrupts, strobes the CSR file and redirects fetch.
module exc_commit_ctrl #(
    parameter int EX_CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    exc_commit_ctrl_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_int_pend;
    logic [31:0]         r_redirect_pc;
    logic [EX_CNT_W-1:0] r_ex_cnt;
    logic                w_idle;
    logic                w_take_ex;
    logic                w_take_ertn;
    logic [5:0]          w_ecode;

    assign w_idle      = (r_state == IDLE);
    assign w_take_ex   = w_idle & bus.wb_valid & (r_int_pend | (|bus.wb_exc));
    assign w_take_ertn = w_idle & bus.wb_valid & bus.wb_ertn & ~w_take_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_take_ex || w_take_ertn) w_next_state = REDIR;
            REDIR:   if (bus.redirect_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Interrupt outranks every synchronous exception; among those, the lowest flag bit wins.
    always_comb begin
        w_ecode = 6'h00;
        if (r_int_pend)         w_ecode = 6'h00;
        else if (bus.wb_exc[0]) w_ecode = 6'h08;
        else if (bus.wb_exc[1]) w_ecode = 6'h0D;
        else if (bus.wb_exc[2]) w_ecode = 6'h0B;
        else if (bus.wb_exc[3]) w_ecode = 6'h0C;
        else if (bus.wb_exc[4]) w_ecode = 6'h09;
    end

    always_comb begin
        bus.wb_ex          = w_take_ex;
        bus.wb_ecode       = w_take_ex ? w_ecode : 6'h00;
        bus.wb_esubcode    = 9'h000;
        bus.ex_pc          = bus.wb_pc;
        bus.ex_vaddr       = bus.wb_vaddr;
        bus.ertn_flush     = w_take_ertn;
        bus.wb_commit      = w_idle & bus.wb_valid & ~w_take_ex;
        bus.flush          = w_take_ex | w_take_ertn | ~w_idle;
        bus.redirect_valid = ~w_idle;
        bus.redirect_pc    = r_redirect_pc;
        bus.ex_cnt         = r_ex_cnt;
    end

    // EENTRY/ERA are sampled at the commit edge, before the CSR file reacts to the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_int_pend    <= 1'b0;
            r_redirect_pc <= 32'h0000_0000;
            r_ex_cnt      <= '0;
        end else begin
            r_int_pend <= bus.crmd_ie & (|(bus.estat_is & bus.ecfg_lie));
            if (w_take_ex) begin
                r_redirect_pc <= bus.eentry;
                r_ex_cnt      <= r_ex_cnt + {{(EX_CNT_W-1){1'b0}}, 1'b1};
            end else if (w_take_ertn) begin
                r_redirect_pc <= bus.era;
            end
        end
    end
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: a cycle-level reference model predicts every
// output for each driven cycle and a separate monitor compares the DUT against it.
module tb_exc_commit_ctrl;
    localparam int CW = 4;

    typedef struct {
        bit          rst;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic [4:0]  exc;
        bit          ertn;
        bit          ie;
        logic [12:0] lie;
        logic [12:0] is;
        logic [31:0] ee;
        logic [31:0] er;
        bit          ready;
    } stim_t;

    typedef struct {
        logic          wbEx;
        logic [5:0]    ecode;
        logic [8:0]    esub;
        logic [31:0]   exPc;
        logic [31:0]   exVaddr;
        logic          ertnFlush;
        logic          commit;
        logic          flush;
        logic          rValid;
        logic [31:0]   rPc;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exc_commit_ctrl_if #(.EX_CNT_W(CW)) bus();
    exc_commit_ctrl #(.EX_CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t  sbQueue[$];
    int    errors = 0;
    int    checks = 0;

    bit          mInRedir = 0;
    bit          mIntPend = 0;
    logic [31:0] mRedirPc = 0;
    int          mExCnt   = 0;

    logic [5:0] excEcode [5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

    function automatic logic [5:0] refEcode(input bit pend, input logic [4:0] exc);
        if (pend) return 6'h00;
        for (int i = 0; i < 5; i++)
            if (exc[i]) return excEcode[i];
        return 6'h00;
    endfunction

    function automatic stim_t defaultStim();
        stim_t s;
        s.rst = 0; s.valid = 0; s.pc = $urandom; s.vaddr = $urandom;
        s.exc = 5'b0; s.ertn = 0; s.ie = 0; s.lie = 13'h0; s.is = 13'h0;
        s.ee = 32'h1C00_8000; s.er = 32'h1C00_0040; s.ready = 1;
        return s;
    endfunction

    // Drives one cycle, records what the DUT must show in it, then advances the model.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit takeEx, takeErtn;
        @(negedge clk);
        reset              = s.rst;
        bus.wb_valid       = s.valid;
        bus.wb_pc          = s.pc;
        bus.wb_vaddr       = s.vaddr;
        bus.wb_exc         = s.exc;
        bus.wb_ertn        = s.ertn;
        bus.crmd_ie        = s.ie;
        bus.ecfg_lie       = s.lie;
        bus.estat_is       = s.is;
        bus.eentry         = s.ee;
        bus.era            = s.er;
        bus.redirect_ready = s.ready;

        takeEx   = !mInRedir && s.valid && (mIntPend || s.exc != 5'b0);
        takeErtn = !mInRedir && s.valid && s.ertn && !takeEx;
        e.wbEx      = takeEx;
        e.ecode     = takeEx ? refEcode(mIntPend, s.exc) : 6'h00;
        e.esub      = 9'h000;
        e.exPc      = s.pc;
        e.exVaddr   = s.vaddr;
        e.ertnFlush = takeErtn;
        e.commit    = !mInRedir && s.valid && !takeEx;
        e.flush     = takeEx || takeErtn || mInRedir;
        e.rValid    = mInRedir;
        e.rPc       = mRedirPc;
        e.cnt       = mExCnt[CW-1:0];
        sbQueue.push_back(e);

        if (s.rst) begin
            mInRedir = 0; mIntPend = 0; mRedirPc = 0; mExCnt = 0;
        end else begin
            if (!mInRedir) begin
                if (takeEx) begin
                    mInRedir = 1; mRedirPc = s.ee; mExCnt = (mExCnt + 1) % (1 << CW);
                end else if (takeErtn) begin
                    mInRedir = 1; mRedirPc = s.er;
                end
            end else if (s.ready) begin
                mInRedir = 0;
            end
            mIntPend = s.ie && ((s.is & s.lie) != 13'h0);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        chk("wb_ex",          32'(bus.wb_ex),          32'(e.wbEx));
        chk("wb_ecode",       32'(bus.wb_ecode),       32'(e.ecode));
        chk("wb_esubcode",    32'(bus.wb_esubcode),    32'(e.esub));
        chk("ex_pc",          bus.ex_pc,               e.exPc);
        chk("ex_vaddr",       bus.ex_vaddr,            e.exVaddr);
        chk("ertn_flush",     32'(bus.ertn_flush),     32'(e.ertnFlush));
        chk("wb_commit",      32'(bus.wb_commit),      32'(e.commit));
        chk("flush",          32'(bus.flush),          32'(e.flush));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rValid));
        chk("redirect_pc",    bus.redirect_pc,         e.rPc);
        chk("ex_cnt",         32'(bus.ex_cnt),         32'(e.cnt));
    endtask

    // Monitor samples mid-low-phase, well clear of the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        s = defaultStim();
        reset = 1'b1;
        bus.wb_valid = 0; bus.wb_pc = 0; bus.wb_vaddr = 0; bus.wb_exc = 0; bus.wb_ertn = 0;
        bus.crmd_ie = 0; bus.ecfg_lie = 0; bus.estat_is = 0; bus.eentry = 0; bus.era = 0;
        bus.redirect_ready = 0;
        repeat (2) @(posedge clk);

        s = defaultStim(); s.rst = 1; s.valid = 1; applyStimulus(s);
        s = defaultStim(); s.valid = 1; applyStimulus(s);

        // SYS exception and its redirect toward EENTRY.
        s = defaultStim(); s.valid = 1; s.exc = 5'b00100; s.pc = 32'h1C00_0010; applyStimulus(s);
        s = defaultStim(); s.valid = 1; applyStimulus(s);
        s = defaultStim(); applyStimulus(s);

        // Interrupt beats exception flags, then flags alone pick ADEF.
        s = defaultStim(); s.ie = 1; s.lie[11] = 1; s.is[11] = 1; applyStimulus(s);
        s.valid = 1; s.exc = 5'b10011; applyStimulus(s);
        s = defaultStim(); applyStimulus(s);
        s = defaultStim(); applyStimulus(s);
        s = defaultStim(); s.valid = 1; s.exc = 5'b10011; applyStimulus(s);
        s = defaultStim(); applyStimulus(s);

        // ertn toward ERA; ertn together with an exception loses.
        s = defaultStim(); s.valid = 1; s.ertn = 1; applyStimulus(s);
        s = defaultStim(); applyStimulus(s);
        s = defaultStim(); s.valid = 1; s.ertn = 1; s.exc = 5'b01000; applyStimulus(s);
        s = defaultStim(); applyStimulus(s);

        // Redirect stalled by fetch while writeback keeps presenting an exception.
        s = defaultStim(); s.valid = 1; s.exc = 5'b00001; s.ee = 32'h1C00_9000; applyStimulus(s);
        for (int i = 0; i < 4; i++) begin
            s = defaultStim(); s.valid = 1; s.exc = 5'b00001; s.ready = 0; applyStimulus(s);
        end
        s = defaultStim(); s.valid = 1; s.exc = 5'b00001; applyStimulus(s);
        s = defaultStim(); s.valid = 1; applyStimulus(s);

        // Interrupt latency with IE set, then the same with IE clear.
        for (int k = 0; k < 2; k++) begin
            s = defaultStim(); s.valid = 1; s.ie = (k == 0); s.lie[11] = 1; s.is[11] = 1;
            applyStimulus(s);
            s.valid = 0; applyStimulus(s);
            s.valid = 1; applyStimulus(s);
            s = defaultStim(); applyStimulus(s);
            s = defaultStim(); applyStimulus(s);
        end

        // Reset while redirecting, then a clean commit.
        s = defaultStim(); s.valid = 1; s.exc = 5'b00010; applyStimulus(s);
        s = defaultStim(); s.rst = 1; s.ready = 0; applyStimulus(s);
        s = defaultStim(); s.valid = 1; applyStimulus(s);

        // Enough back-to-back exceptions to wrap the counter.
        for (int i = 0; i < 18; i++) begin
            s = defaultStim(); s.valid = 1; s.exc = 5'b01000; s.ee = $urandom; applyStimulus(s);
            s = defaultStim(); applyStimulus(s);
        end

        for (int i = 0; i < 1500; i++) begin
            s = defaultStim();
            s.rst   = ($urandom_range(0, 99) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.exc   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            s.ertn  = ($urandom_range(0, 5) == 0);
            s.ie    = $urandom_range(0, 1);
            s.lie   = 13'($urandom) & 13'($urandom);
            s.is    = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'h0;
            s.ee    = $urandom;
            s.er    = $urandom;
            s.ready = $urandom_range(0, 1);
            applyStimulus(s);
        end

        #3;
        for (int i = 0; i < 20 && sbQueue.size() != 0; i++) @(negedge clk);
        #3;
        checks++;
        if (sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sbQueue.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
